// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator producing sync pulses, visible-area
// flag, pixel coordinates, optional replicated (scaled) coordinates and
// line/frame strobes. Outputs are registered one enabled tick after the
// internal counters.
// Optional feature macro: VTG_SCALE_EN enables the x_scaled/y_scaled counters;
// without it both ports are tied to zero.
module video_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int SCALE     = 10,
  parameter int CW        = 10,
  parameter int SW        = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          h_sync,
  output logic          v_sync,
  output logic          display_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [SW-1:0] x_scaled,
  output logic [SW-1:0] y_scaled,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  // One spare bit of headroom so sync-end values equal to the total still fit.
  localparam int HCW = $clog2(H_TOTAL + 1);
  localparam int VCW = $clog2(V_TOTAL + 1);

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_VIS    = HCW'(H_DISPLAY);
  localparam logic [HCW-1:0] HS_START = HCW'(H_DISPLAY + H_FRONT);
  localparam logic [HCW-1:0] HS_END   = HCW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_VIS    = VCW'(V_DISPLAY);
  localparam logic [VCW-1:0] VS_START = VCW'(V_DISPLAY + V_FRONT);
  localparam logic [VCW-1:0] VS_END   = VCW'(V_DISPLAY + V_FRONT + V_SYNC);

  if (SCALE < 1 || SCALE > 16) begin : g_scale_chk
    $error("video_timing_gen: SCALE must lie in 1..16");
  end

  logic [HCW-1:0] hc_q, hc_d;
  logic [VCW-1:0] vc_q, vc_d;
  logic           h_wrap, v_wrap;

  logic           h_sync_q, v_sync_q, display_en_q, line_start_q, frame_start_q;
  logic           h_sync_d, v_sync_d, display_en_d, line_start_d, frame_start_d;
  logic [CW-1:0]  x_q, y_q, x_d, y_d;

  // Next raster position and the output values decoded from the current one.
  always_comb begin
    h_wrap = (hc_q == H_LAST);
    v_wrap = (vc_q == V_LAST);
    hc_d   = h_wrap ? '0 : hc_q + HCW'(1);
    vc_d   = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? '0 : vc_q + VCW'(1);
    end
    h_sync_d      = ((hc_q >= HS_START) && (hc_q < HS_END)) ? HS_POL : ~HS_POL;
    v_sync_d      = ((vc_q >= VS_START) && (vc_q < VS_END)) ? VS_POL : ~VS_POL;
    display_en_d  = (hc_q < H_VIS) && (vc_q < V_VIS);
    line_start_d  = (hc_q == '0);
    frame_start_d = (hc_q == '0) && (vc_q == '0);
    x_d           = CW'(hc_q);
    y_d           = CW'(vc_q);
  end

  // Advance counters and register outputs on enabled ticks; reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc_q          <= '0;
      vc_q          <= '0;
      h_sync_q      <= ~HS_POL;
      v_sync_q      <= ~VS_POL;
      display_en_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else if (enable) begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      display_en_q  <= display_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign display_en  = display_en_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign x           = x_q;
  assign y           = y_q;

`ifdef VTG_SCALE_EN
  localparam int SCW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SCW-1:0] SUB_LAST = SCW'(SCALE - 1);

  logic [SCW-1:0] hsub_q, hsub_d, vsub_q, vsub_d;
  logic [SW-1:0]  hsc_q, hsc_d, vsc_q, vsc_d;
  logic [SW-1:0]  x_scaled_q, y_scaled_q;

  // Replication sub-counters track hc/vc so hsc = hc/SCALE, vsc = vc/SCALE.
  always_comb begin
    hsub_d = hsub_q + SCW'(1);
    hsc_d  = hsc_q;
    if (h_wrap) begin
      hsub_d = '0;
      hsc_d  = '0;
    end else if (hsub_q == SUB_LAST) begin
      hsub_d = '0;
      hsc_d  = hsc_q + SW'(1);
    end
    vsub_d = vsub_q;
    vsc_d  = vsc_q;
    if (h_wrap) begin
      if (v_wrap) begin
        vsub_d = '0;
        vsc_d  = '0;
      end else if (vsub_q == SUB_LAST) begin
        vsub_d = '0;
        vsc_d  = vsc_q + SW'(1);
      end else begin
        vsub_d = vsub_q + SCW'(1);
      end
    end
  end

  // Scaled counters step with hc/vc; their outputs share the common latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsub_q     <= '0;
      vsub_q     <= '0;
      hsc_q      <= '0;
      vsc_q      <= '0;
      x_scaled_q <= '0;
      y_scaled_q <= '0;
    end else if (enable) begin
      hsub_q     <= hsub_d;
      vsub_q     <= vsub_d;
      hsc_q      <= hsc_d;
      vsc_q      <= vsc_d;
      x_scaled_q <= hsc_q;
      y_scaled_q <= vsc_q;
    end
  end

  assign x_scaled = x_scaled_q;
  assign y_scaled = y_scaled_q;
`else
  assign x_scaled = '0;
  assign y_scaled = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen: a reduced-size instance under randomized
// enable/reset and a default-size instance running free.
module tb_video_timing_gen;

`ifdef VTG_SCALE_EN
  localparam bit SC_ON = 1'b1;
`else
  localparam bit SC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en_s = 1'b0;
  logic en_d = 1'b1;

  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [5:0] s_x, s_y;
  logic [2:0] s_xs, s_ys;

  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [5:0] d_xs, d_ys;

  video_timing_gen #(
    .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
    .HS_POL(1'b1), .VS_POL(1'b0), .SCALE(3), .CW(6), .SW(3)
  ) dut_s (
    .clk(clk), .reset(rst), .enable(en_s),
    .h_sync(s_hs), .v_sync(s_vs), .display_en(s_de),
    .x(s_x), .y(s_y), .x_scaled(s_xs), .y_scaled(s_ys),
    .line_start(s_ls), .frame_start(s_fs)
  );

  video_timing_gen dut_d (
    .clk(clk), .reset(rst), .enable(en_d),
    .h_sync(d_hs), .v_sync(d_vs), .display_en(d_de),
    .x(d_x), .y(d_y), .x_scaled(d_xs), .y_scaled(d_ys),
    .line_start(d_ls), .frame_start(d_fs)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs after k enabled ticks since reset (k=0: reset values).
  task automatic check_dut(input string tag, input int k,
                           input int hd, input int hf, input int hsy, input int hb,
                           input int vd, input int vf, input int vsy, input int vb,
                           input bit hp, input bit vp, input int scale,
                           input int sw, input int cw,
                           input bit a_hs, input bit a_vs, input bit a_de,
                           input bit a_ls, input bit a_fs,
                           input int a_x, input int a_y, input int a_xs, input int a_ys);
    int ht, vt, n, h, v;
    bit e_hs, e_vs, e_de, e_ls, e_fs;
    int e_x, e_y, e_xs, e_ys;
    ht = hd + hf + hsy + hb;
    vt = vd + vf + vsy + vb;
    if (k == 0) begin
      e_hs = ~hp; e_vs = ~vp; e_de = 0; e_ls = 0; e_fs = 0;
      e_x = 0; e_y = 0; e_xs = 0; e_ys = 0;
    end else begin
      n = k - 1;
      h = n % ht;
      v = (n / ht) % vt;
      e_hs = (h >= hd + hf && h < hd + hf + hsy) ? hp : ~hp;
      e_vs = (v >= vd + vf && v < vd + vf + vsy) ? vp : ~vp;
      e_de = (h < hd) && (v < vd);
      e_ls = (h == 0);
      e_fs = (h == 0) && (v == 0);
      e_x  = h % (1 << cw);
      e_y  = v % (1 << cw);
      e_xs = SC_ON ? (h / scale) % (1 << sw) : 0;
      e_ys = SC_ON ? (v / scale) % (1 << sw) : 0;
    end
    chk({tag, ".h_sync"}, int'(a_hs), int'(e_hs));
    chk({tag, ".v_sync"}, int'(a_vs), int'(e_vs));
    chk({tag, ".display_en"}, int'(a_de), int'(e_de));
    chk({tag, ".line_start"}, int'(a_ls), int'(e_ls));
    chk({tag, ".frame_start"}, int'(a_fs), int'(e_fs));
    chk({tag, ".x"}, a_x, e_x);
    chk({tag, ".y"}, a_y, e_y);
    chk({tag, ".x_scaled"}, a_xs, e_xs);
    chk({tag, ".y_scaled"}, a_ys, e_ys);
  endtask

  initial begin
    int ks, kd, rst_left, last_fs, last_ls, n, sh, sv;
    bit mid_done;
    ks = 0; kd = 0; rst_left = 0; last_fs = -1; last_ls = -1; mid_done = 0;

    for (int cyc = 0; cyc < 7000; cyc++) begin
      // Drive inputs away from the active edge.
      if (ks > 0) begin
        n  = ks - 1;
        sh = n % 32;
        sv = (n / 32) % 21;
        if (!mid_done && cyc > 1200 && sh == 10 && sv == 7) begin
          rst_left = 2;
          mid_done = 1;
        end
      end
      if (cyc == 5000) rst_left = 3;
      rst  = (cyc < 3) || (rst_left > 0);
      if (rst_left > 0) rst_left--;
      en_s = (cyc < 3500) ? ($urandom % 4 != 0) : (cyc % 4 == 0);

      @(posedge clk);
      if (rst) begin
        ks = 0; kd = 0;
      end else begin
        if (en_s) ks++;
        if (en_d) kd++;
      end
      #1;

      check_dut("s", ks, 20, 3, 4, 5, 12, 2, 3, 4, 1'b1, 1'b0, 3, 3, 6,
                s_hs, s_vs, s_de, s_ls, s_fs, int'(s_x), int'(s_y), int'(s_xs), int'(s_ys));
      check_dut("d", kd, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 10, 6, 10,
                d_hs, d_vs, d_de, d_ls, d_fs, int'(d_x), int'(d_y), int'(d_xs), int'(d_ys));

      if (rst) begin
        last_fs = -1;
        last_ls = -1;
        chk("rst.s_h_sync_inactive", int'(s_hs), 0);
        chk("rst.s_v_sync_inactive", int'(s_vs), 1);
        chk("rst.d_h_sync_inactive", int'(d_hs), 1);
      end else if (en_s) begin
        if (s_fs) begin
          if (last_fs >= 0) chk("s.frame_period", ks - last_fs, 672);
          last_fs = ks;
        end
        if (s_ls) begin
          if (last_ls >= 0) chk("s.line_period", ks - last_ls, 32);
          last_ls = ks;
        end
        if (ks == 1) begin
          chk("s.first_frame_start", int'(s_fs), 1);
          chk("s.first_x", int'(s_x), 0);
          chk("s.first_y", int'(s_y), 0);
        end
        if (ks == 31) chk("s.x_scaled_wrap_sw", int'(s_xs), SC_ON ? 2 : 0);
        if (ks == 33) chk("s.x_scaled_line_restart", int'(s_xs), 0);
        if (ks == 372) begin
          chk("s.x_scaled_last_vis", int'(s_xs), SC_ON ? 6 : 0);
          chk("s.y_scaled_last_vis", int'(s_ys), SC_ON ? 3 : 0);
        end
      end

      if (!rst) begin
        if (kd == 656) chk("d.h_sync_t656", int'(d_hs), 1);
        if (kd == 657) chk("d.h_sync_t657", int'(d_hs), 0);
        if (kd == 752) chk("d.h_sync_t752", int'(d_hs), 0);
        if (kd == 753) chk("d.h_sync_t753", int'(d_hs), 1);
        if (kd == 801) begin
          chk("d.line_start_t801", int'(d_ls), 1);
          chk("d.x_t801", int'(d_x), 0);
          chk("d.y_t801", int'(d_y), 1);
          chk("d.frame_start_t801", int'(d_fs), 0);
        end
      end

      @(negedge clk);
    end

    chk("mid_frame_reset_issued", int'(mid_done), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16; H_SYNC, default 96; H_BACK, default 48: horizontal porch/sync lengths in pixels.
REQ-003 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-004 Parameter V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33: vertical porch/sync lengths in lines.
REQ-005 Parameter HS_POL, default 0; VS_POL, default 0: active level of h_sync and v_sync.
REQ-006 Parameter SCALE, default 10, pixel-replication factor for scaled coordinates, legal range 1..16.
REQ-007 Parameter CW, default 10, width of x and y; SW, default 6, width of x_scaled and y_scaled.
REQ-008 clk  input  1  single clock; all state changes on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 enable  input  1  pixel-rate tick; state advances only on clk edges where enable=1.
REQ-011 h_sync, v_sync  output  1 each  sync pulses at levels HS_POL and VS_POL.
REQ-012 display_en  output  1  high while the current pixel is in the visible area.
REQ-013 x, y  output  CW each  current pixel column and line.
REQ-014 x_scaled, y_scaled  output  SW each  column/SCALE and line/SCALE.
REQ-015 line_start, frame_start  output  1 each  single-tick strobes.

Function
REQ-016 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK.
REQ-017 Internal hc counts 0..H_TOTAL-1 on enabled edges and wraps to 0; vc increments when hc wraps, counts 0..V_TOTAL-1 and wraps to 0.
REQ-018 All outputs shall be registered from hc/vc on the same enabled edge: 1 enabled-tick latency, all outputs mutually aligned.
REQ-019 h_sync = HS_POL when H_DISPLAY+H_FRONT <= hc < H_DISPLAY+H_FRONT+H_SYNC, else ~HS_POL.
REQ-020 v_sync = VS_POL when V_DISPLAY+V_FRONT <= vc < V_DISPLAY+V_FRONT+V_SYNC, else ~VS_POL.
REQ-021 display_en = (hc < H_DISPLAY) && (vc < V_DISPLAY).
REQ-022 x = hc, y = vc, truncated to CW bits.
REQ-023 line_start = 1 for exactly one enabled tick, when hc = 0; frame_start = 1 when hc = 0 and vc = 0.
REQ-024 A per-axis sub-counter counts 0..SCALE-1; on wrap, the scaled counter increments (modulo 2^SW); both clear when the base axis counter wraps.
REQ-025 enable = 0: all counters and outputs hold; strobes hold their value (outputs do not self-clear).
REQ-026 Reset takes priority over enable.

Reset
REQ-027 On reset: hc, vc, sub-counters = 0; x, y, x_scaled, y_scaled = 0; display_en, line_start, frame_start = 0; h_sync = ~HS_POL; v_sync = ~VS_POL.
REQ-028 Reset asserted mid-frame shall abort the frame; the first enabled tick after release shall present hc = vc = 0, with line_start = frame_start = 1.

Configuration
REQ-029 Macro VTG_SCALE_EN defined: x_scaled/y_scaled behave per REQ-024.
REQ-030 Macro VTG_SCALE_EN undefined: scaler logic is omitted, x_scaled and y_scaled are tied to 0, ports remain present, and all other behaviour is unchanged.

Verification
REQ-031 Defaults, enable=1, reset released; tick 1 = first output after release -> h_sync low on ticks 657..752 (96 ticks) of each line, high otherwise.
REQ-032 Defaults, run 2 frames -> frame_start pulses 420000 ticks apart; line_start pulses every 800 ticks; display_en high on 640x480 = 307200 ticks per frame.
REQ-033 Defaults -> v_sync low for exactly 1600 ticks, while y = 490..491.
REQ-034 enable high 1 clk in 4 -> all periods x4 in clk cycles; outputs stable on non-enabled clocks.
REQ-035 VTG_SCALE_EN defined, SCALE=10 -> at x=639, y=479: x_scaled=63, y_scaled=47; x_scaled returns to 0 at x=0. Undefined -> both read 0 throughout.
REQ-036 Reset pulsed at x=300, y=200 -> next enabled output gives x=0, y=0, frame_start=1; h_sync and v_sync are inactive during reset.
